// File: rtl/alu_word_sequencer.sv
// Word-serial ALU engine: runs an NSLICE x WIDTH command one slice per clock, LSB slice first.
// Optional macro ALU_WORD_SEQUENCER_OVF_EN adds a registered two's-complement overflow flag (out_ovf).
module alu_word_sequencer #(
    parameter int unsigned WIDTH  = 8,
    parameter int unsigned NSLICE = 4
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [WIDTH*NSLICE-1:0]   in_a,
    input  logic [WIDTH*NSLICE-1:0]   in_b,
    input  logic                      in_cin,
    input  logic [1:0]                in_op,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [WIDTH*NSLICE-1:0]   out_result,
    output logic                      out_cout,
`ifdef ALU_WORD_SEQUENCER_OVF_EN
    output logic                      out_ovf,
`endif
    output logic                      busy
);

    localparam int unsigned W     = WIDTH * NSLICE;
    localparam int unsigned IDX_W = $clog2(NSLICE);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NSLICE - 1);

    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_SUB = 2'b01;
    localparam logic [1:0] OP_AND = 2'b10;
    localparam logic [1:0] OP_OR  = 2'b11;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t             state;
    state_t             state_next;
    logic               load;
    logic               step;
    logic               last;

    logic [W-1:0]       a_q;
    logic [W-1:0]       b_q;
    logic [1:0]         op_q;
    logic               carry_q;
    logic [IDX_W-1:0]   idx_q;

    logic [WIDTH-1:0]   a_k;
    logic [WIDTH-1:0]   b_k;
    logic [WIDTH-1:0]   b_eff;
    logic [WIDTH:0]     sum;
    logic [WIDTH-1:0]   r_k;
    logic               c_k;
`ifdef ALU_WORD_SEQUENCER_OVF_EN
    logic [WIDTH-1:0]   low_sum;
    logic               ovf_k;
`endif

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_next;
    end

    // Next-state and datapath strobes
    always_comb begin
        state_next = state;
        load       = 1'b0;
        step       = 1'b0;
        last       = 1'b0;
        case (state)
            IDLE: begin
                if (in_valid) begin
                    load       = 1'b1;
                    state_next = RUN;
                end
            end
            RUN: begin
                step = 1'b1;
                if (idx_q == LAST_IDX) begin
                    last       = 1'b1;
                    state_next = DONE;
                end
            end
            DONE: begin
                if (out_ready) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // Handshake/status flags registered from the next state so they track state exactly
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            in_ready  <= 1'b1;
            busy      <= 1'b0;
            out_valid <= 1'b0;
        end else begin
            in_ready  <= (state_next == IDLE);
            busy      <= (state_next != IDLE);
            out_valid <= (state_next == DONE);
        end
    end

    // Slice ALU; operands shift down so the active slice is always the low WIDTH bits
    always_comb begin
        a_k   = a_q[WIDTH-1:0];
        b_k   = b_q[WIDTH-1:0];
        b_eff = (op_q == OP_SUB) ? ~b_k : b_k;
        sum   = {1'b0, a_k} + {1'b0, b_eff} + {{WIDTH{1'b0}}, carry_q};
        r_k   = sum[WIDTH-1:0];
        c_k   = sum[WIDTH];
        case (op_q)
            OP_AND: begin
                r_k = a_k & b_k;
                c_k = 1'b0;
            end
            OP_OR: begin
                r_k = a_k | b_k;
                c_k = 1'b0;
            end
            default: ;
        endcase
    end

`ifdef ALU_WORD_SEQUENCER_OVF_EN
    // Carry into the slice MSB, compared against carry out of it
    always_comb begin
        low_sum = {1'b0, a_k[WIDTH-2:0]} + {1'b0, b_eff[WIDTH-2:0]}
                + {{(WIDTH-1){1'b0}}, carry_q};
        ovf_k   = (op_q == OP_ADD || op_q == OP_SUB) ? (low_sum[WIDTH-1] ^ sum[WIDTH]) : 1'b0;
    end
`endif

    // Operand/result shift registers and carry chain
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q        <= '0;
            b_q        <= '0;
            op_q       <= OP_ADD;
            carry_q    <= 1'b0;
            idx_q      <= '0;
            out_result <= '0;
            out_cout   <= 1'b0;
`ifdef ALU_WORD_SEQUENCER_OVF_EN
            out_ovf    <= 1'b0;
`endif
        end else if (load) begin
            a_q     <= in_a;
            b_q     <= in_b;
            op_q    <= in_op;
            carry_q <= in_cin;
            idx_q   <= '0;
        end else if (step) begin
            a_q        <= a_q >> WIDTH;
            b_q        <= b_q >> WIDTH;
            out_result <= {r_k, out_result[W-1:WIDTH]};
            carry_q    <= c_k;
            idx_q      <= last ? '0 : idx_q + IDX_W'(1);
            if (last) begin
                out_cout <= c_k;
`ifdef ALU_WORD_SEQUENCER_OVF_EN
                out_ovf  <= ovf_k;
`endif
            end
        end
    end

endmodule

// File: tb/tb_alu_word_sequencer.sv
// Directed self-checking bench for alu_word_sequencer (WIDTH=8, NSLICE=4).
// Define ALU_WORD_SEQUENCER_OVF_EN for both files to exercise out_ovf.
module tb_alu_word_sequencer;

    localparam int unsigned WIDTH  = 8;
    localparam int unsigned NSLICE = 4;
    localparam int unsigned W      = WIDTH * NSLICE;

    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_SUB = 2'b01;
    localparam logic [1:0] OP_AND = 2'b10;
    localparam logic [1:0] OP_OR  = 2'b11;

    logic           clk;
    logic           rst_n;
    logic           in_valid;
    logic           in_ready;
    logic [W-1:0]   in_a;
    logic [W-1:0]   in_b;
    logic           in_cin;
    logic [1:0]     in_op;
    logic           out_valid;
    logic           out_ready;
    logic [W-1:0]   out_result;
    logic           out_cout;
    logic           busy;
`ifdef ALU_WORD_SEQUENCER_OVF_EN
    logic           out_ovf;
`endif

    int n_vec;
    int n_miss;

    alu_word_sequencer #(.WIDTH(WIDTH), .NSLICE(NSLICE)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_a       (in_a),
        .in_b       (in_b),
        .in_cin     (in_cin),
        .in_op      (in_op),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_result (out_result),
        .out_cout   (out_cout),
`ifdef ALU_WORD_SEQUENCER_OVF_EN
        .out_ovf    (out_ovf),
`endif
        .busy       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_miss++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present one command for the accepting edge, then scramble the inputs
    task automatic send(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic cin);
        in_valid = 1'b1;
        in_op    = op;
        in_a     = a;
        in_b     = b;
        in_cin   = cin;
        tick();
        in_valid = 1'b0;
        in_a     = 32'hDEADBEEF;
        in_b     = 32'hCAFEF00D;
        in_op    = ~op;
        in_cin   = ~cin;
    endtask

    task automatic wait_valid(input string tag);
        int cyc;
        cyc = 0;
        while (!out_valid && cyc < 20) begin
            tick();
            cyc++;
        end
        check({tag, " latency"}, 64'(cyc), 64'(NSLICE));
    endtask

    task automatic take(input string tag);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check({tag, " out_valid after take"}, 64'(out_valid), 64'd0);
        check({tag, " in_ready after take"}, 64'(in_ready), 64'd1);
    endtask

    task automatic run_vec(input string tag, input logic [1:0] op, input logic [W-1:0] a,
                           input logic [W-1:0] b, input logic cin, input logic [W-1:0] exp_r,
                           input logic exp_c, input logic exp_o);
        check({tag, " in_ready"}, 64'(in_ready), 64'd1);
        send(op, a, b, cin);
        check({tag, " busy"}, 64'(busy), 64'd1);
        wait_valid(tag);
        check({tag, " result"}, 64'(out_result), 64'(exp_r));
        check({tag, " cout"}, 64'(out_cout), 64'(exp_c));
`ifdef ALU_WORD_SEQUENCER_OVF_EN
        check({tag, " ovf"}, 64'(out_ovf), 64'(exp_o));
`else
        if (exp_o) begin end
`endif
        check({tag, " in_ready in DONE"}, 64'(in_ready), 64'd0);
        take(tag);
    endtask

    initial begin
        n_vec     = 0;
        n_miss    = 0;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_a      = '0;
        in_b      = '0;
        in_cin    = 1'b0;
        in_op     = OP_ADD;
        out_ready = 1'b0;

        repeat (3) tick();
        check("rst out_valid", 64'(out_valid), 64'd0);
        check("rst busy", 64'(busy), 64'd0);
        check("rst result", 64'(out_result), 64'd0);
        check("rst cout", 64'(out_cout), 64'd0);
        rst_n = 1'b1;
        tick();
        check("post-rst in_ready", 64'(in_ready), 64'd1);

        run_vec("add_wrap", OP_ADD, 32'hFFFFFFFF, 32'h00000001, 1'b0, 32'h00000000, 1'b1, 1'b0);
        run_vec("add_cin",  OP_ADD, 32'h000000FF, 32'h00000000, 1'b1, 32'h00000100, 1'b0, 1'b0);
        run_vec("sub_neg",  OP_SUB, 32'h00000000, 32'h00000001, 1'b1, 32'hFFFFFFFF, 1'b0, 1'b0);
        run_vec("sub_pos",  OP_SUB, 32'h12345678, 32'h02345678, 1'b1, 32'h10000000, 1'b1, 1'b0);
        run_vec("and",      OP_AND, 32'hF0F0F0F0, 32'hFF00FF00, 1'b1, 32'hF000F000, 1'b0, 1'b0);
        run_vec("or",       OP_OR,  32'hF0F0F0F0, 32'hFF00FF00, 1'b1, 32'hFFF0FFF0, 1'b0, 1'b0);
        run_vec("add_ovf",  OP_ADD, 32'h7FFFFFFF, 32'h00000001, 1'b0, 32'h80000000, 1'b0, 1'b1);

        // Back-pressure: DONE held while a new command waits at the input
        send(OP_ADD, 32'h00000001, 32'h00000002, 1'b0);
        wait_valid("bp first");
        in_valid = 1'b1;
        in_op    = OP_ADD;
        in_a     = 32'h00000010;
        in_b     = 32'h00000020;
        in_cin   = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            check("bp held result", 64'(out_result), 64'h3);
            check("bp held valid", 64'(out_valid), 64'd1);
            check("bp in_ready", 64'(in_ready), 64'd0);
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check("bp release out_valid", 64'(out_valid), 64'd0);
        check("bp release in_ready", 64'(in_ready), 64'd1);
        tick();
        in_valid = 1'b0;
        check("bp accepted in_ready", 64'(in_ready), 64'd0);
        check("bp accepted busy", 64'(busy), 64'd1);
        wait_valid("bp second");
        check("bp second result", 64'(out_result), 64'h30);
        take("bp second");

        // Reset mid-RUN after slice 1
        send(OP_ADD, 32'h11111111, 32'h22222222, 1'b0);
        tick();
        tick();
        check("midrst busy before", 64'(busy), 64'd1);
        rst_n = 1'b0;
        #1;
        check("midrst out_valid", 64'(out_valid), 64'd0);
        check("midrst busy", 64'(busy), 64'd0);
        check("midrst result", 64'(out_result), 64'd0);
        tick();
        rst_n = 1'b1;
        tick();
        check("midrst out_valid after", 64'(out_valid), 64'd0);
        run_vec("add_after_rst", OP_ADD, 32'h00000002, 32'h00000003, 1'b0, 32'h00000005, 1'b0, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule

// File: doc/alu_word_sequencer.md
# alu_word_sequencer

Word-serial arithmetic engine that drives a WIDTH-bit ALU slice datapath from the operand side. It accepts a wide command through a valid/ready handshake, processes it one WIDTH-bit slice per clock, least-significant slice first, and chains the carry between slices through a register. It returns the assembled NSLICE×WIDTH result and final carry through a second valid/ready handshake. The block turns the combinational slice ALU into a multi-cycle, wide-word functional unit for the datapath.

## Interface
- WIDTH, 8, bits per slice; the ALU datapath width.
- NSLICE, 4, number of slices per operation; must be ≥ 2. Total word width W = WIDTH×NSLICE.
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset; deassertion is synchronous to clk.
- in_valid  in  1  command valid.
- in_ready  out  1  engine can accept a command.
- in_a  in  W  operand A.
- in_b  in  W  operand B.
- in_cin  in  1  carry-in to slice 0.
- in_op  in  2  operation: 00 ADD, 01 SUB, 10 AND, 11 OR.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts result.
- out_result  out  W  result word.
- out_cout  out  1  carry out of the top slice.
- busy  out  1  high in RUN or DONE.

## Operation
- States: IDLE, RUN, DONE.
- **IDLE**
  - in_ready=1.
  - When in_valid & in_ready are high at a clock edge, the engine latches a, b, op and cin into the carry register, clears the slice index, and moves to RUN.
- **RUN**
  - Each cycle processes slice k = index, covering bits [k×WIDTH +: WIDTH].
  - ADD: {c, r} = a_k + b_k + carry, computed at WIDTH+1 bits.
  - SUB: {c, r} = a_k + ~b_k + carry. Cin=1 means no borrow; cout=1 means no borrow out.
  - AND and OR: r = a_k op b_k; carry is forced to 0.
  - r is written into result slice k; carry register ← c; index increments.
  - After slice NSLICE-1 is processed: out_cout ← c and the state moves to DONE.
- **DONE**
  - out_valid=1; out_result and out_cout are held stable.
  - When out_valid & out_ready are high at an edge, the engine returns to IDLE.
- in_ready is 0 in RUN and DONE. Commands presented then are not accepted and must be held by the producer.
- in_valid is ignored outside IDLE; in_a, in_b, in_op and in_cin may change after acceptance.
- out_result is valid only while out_valid=1. Partially built slices are not required to be hidden.
- Reset values: in_ready=1 once reset deasserts (0 during reset is not required; it is 1 as a function of IDLE). out_valid=0, out_result=0, out_cout=0, busy=0, state IDLE, index 0, carry 0.
- Reset asserted mid-RUN or in DONE abandons the operation immediately; no output handshake occurs.

## Timing
- Accept at edge T0. Slices are processed at edges T1..T(NSLICE). out_valid goes high after edge T(NSLICE), so latency is NSLICE cycles from acceptance to out_valid.
- With out_ready held at 1, the DONE→IDLE handshake completes at edge T(NSLICE+1). in_ready is high in that following cycle, so throughput is one command per NSLICE+2 cycles.
- No combinational path from in_valid to in_ready or from out_ready to out_valid; all outputs come from registers or state decode.
- Back-pressure: out_ready=0 holds DONE indefinitely with outputs unchanged.

## Configuration
- Macro: ALU_WORD_SEQUENCER_OVF_EN.
- **Defined:** adds port out_ovf (out, 1), registered alongside out_cout.
  - For ADD and SUB: out_ovf = carry into the top bit XOR carry out of the top bit of slice NSLICE-1 (two's-complement overflow).
  - For AND and OR: out_ovf = 0.
  - Resets to 0.
- **Undefined:** the port and its logic are absent; all other behaviour is identical.

## Test plan
- ADD, a=0xFFFFFFFF, b=0x00000001, cin=0 → out_result=0x00000000, out_cout=1. out_valid rises exactly 4 cycles after acceptance; with OVF_EN, out_ovf=0.
- SUB, a=0x00000000, b=0x00000001, cin=1 → out_result=0xFFFFFFFF, out_cout=0. Then SUB, a=0x12345678, b=0x02345678, cin=1 → 0x10000000, out_cout=1.
- AND, a=0xF0F0F0F0, b=0xFF00FF00, cin=1 → 0xF000F000, out_cout=0. OR on the same operands → 0xFFF0FFF0, out_cout=0.
- Back-pressure: hold out_ready=0 for 5 cycles in DONE while in_valid=1 with new operands → result held stable, in_ready=0, new command not accepted. Raise out_ready → handshake completes, then the new command is accepted the following cycle.
- Reset: assert rst_n=0 after slice 1 of an ADD → out_valid=0, busy=0, out_result=0 immediately. After release, in_ready=1 and the next ADD 0x00000002+0x00000003 returns 0x00000005.
- With OVF_EN: ADD, a=0x7FFFFFFF, b=0x00000001, cin=0 → out_result=0x80000000, out_ovf=1, out_cout=0.
